beat_rate_meter: RTL and testbench

Downstream consumer of the peak detector's foundPeak output. It measures the clk-cycle interval between accepted peaks and rejects peaks inside a refractory window. It averages the last AVG_DEPTH intervals and converts the average to beats-per-minute with a sequential divider. The 8-bit heart_rate output feeds the getDigits / seven-segment display path.

---
 rtl/hr_pkg.sv | 31 +++
 rtl/seq_divider.sv | 86 ++++++++
 rtl/beat_rate_meter.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_beat_rate_meter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hr_pkg.sv
// Shared definitions for the beat-rate meter.
//   hr_state_t  : tracking FSM states
//   BPM_MAX     : saturation value of the 8-bit heart_rate output
//   DIV_W       : width of the sequential divider datapath
//   log2_depth  : elaboration-time log2 of the (power-of-two) averaging depth
package hr_pkg;

  typedef enum logic [1:0] {
    S_WAIT_FIRST = 2'd0,
    S_TRACK      = 2'd1,
    S_DIV        = 2'd2
  } hr_state_t;

  localparam int BPM_MAX = 255;
  localparam int DIV_W   = 32;

  // Exact log2 for a power-of-two depth.
  function automatic int log2_depth(input int depth);
    int r;
    r = 0;
    for (int k = 1; k < 31; k++) begin
      if ((32'sd1 <<< k) <= depth) begin
        r = k;
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock.
// One cycle loads the operands, DIV_W cycles iterate, then done pulses for
// one cycle while quotient holds the result.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous abort of any division in progress
//   start      : load dividend/divisor and begin (ignored while busy)
//   dividend   : numerator
//   divisor    : denominator (caller guarantees non-zero)
//   busy       : iteration in progress
//   done       : 1-cycle pulse, quotient valid
//   quotient   : result, held until the next start
module seq_divider
  import hr_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient
);

  localparam int ITER_W = $clog2(DIV_W);
  localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(DIV_W - 1);

  logic [DIV_W-1:0]  rem_r;
  logic [DIV_W-1:0]  quo_r;
  logic [DIV_W-1:0]  dvs_r;
  logic [ITER_W-1:0] iter_r;
  logic              busy_r;
  logic              done_r;
  logic [DIV_W:0]    rem_shift_s;
  logic [DIV_W:0]    diff_s;
  logic              ge_s;

  // Partial remainder shifted left with the next dividend bit; the
  // remainder stays below the divisor so DIV_W+1 bits never overflow.
  assign rem_shift_s = {rem_r, quo_r[DIV_W-1]};
  assign diff_s      = rem_shift_s - {1'b0, dvs_r};
  assign ge_s        = (rem_shift_s >= {1'b0, dvs_r});

  // Load, iterate and signal completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dvs_r  <= '0;
      iter_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (clear) begin
      iter_r <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start && !busy_r) begin
      rem_r  <= '0;
      quo_r  <= dividend;
      dvs_r  <= divisor;
      iter_r <= '0;
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      quo_r  <= {quo_r[DIV_W-2:0], ge_s};
      rem_r  <= ge_s ? diff_s[DIV_W-1:0] : rem_shift_s[DIV_W-1:0];
      iter_r <= iter_r + ITER_W'(1);
      if (iter_r == ITER_LAST) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign quotient = quo_r;

endmodule

// File: rtl/beat_rate_meter.sv
// Heart-rate meter fed by the peak detector's foundPeak level.
// Measures the cycle count between accepted peak edges (with a refractory
// window), averages the last AVG_DEPTH intervals and divides 60*CLK_HZ by
// the average to obtain beats per minute.
// Ports:
//   clk         : system clock
//   reset       : asynchronous active-high reset
//   peak_in     : foundPeak level; only its rising edge matters
//   heart_rate  : BPM, saturated at 255
//   rate_valid  : heart_rate comes from a full history
//   rate_update : 1-cycle pulse when heart_rate is rewritten
//   beat_pulse  : 1-cycle pulse per accepted beat
//   timeout     : 1-cycle pulse when MAX_INTERVAL elapses without a beat
// Optional build macro OUTLIER_REJECT_EN: with a full history, intervals
// outside avg +/- avg/4 are not pushed; two in a row flush the history.
module beat_rate_meter
  import hr_pkg::*;
#(
  parameter int CLK_HZ       = 40_000_000,
  parameter int MIN_INTERVAL = 10_000_000,
  parameter int MAX_INTERVAL = 80_000_000,
  parameter int AVG_DEPTH    = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       peak_in,
  output logic [7:0] heart_rate,
  output logic       rate_valid,
  output logic       rate_update,
  output logic       beat_pulse,
  output logic       timeout
);

  localparam int CNT_W  = $clog2(MAX_INTERVAL + 1);
  localparam int AVG_L  = log2_depth(AVG_DEPTH);
  localparam int SUM_W  = CNT_W + AVG_L;
  localparam int FILL_W = AVG_L + 1;
  localparam int PTR_W  = AVG_L;

  localparam logic [CNT_W-1:0]  MIN_CNT   = CNT_W'(MIN_INTERVAL);
  localparam logic [CNT_W-1:0]  MAX_CNT   = CNT_W'(MAX_INTERVAL);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(AVG_DEPTH);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(AVG_DEPTH - 1);
  localparam logic [DIV_W-1:0]  DIVIDEND  = DIV_W'(64'd60 * 64'(CLK_HZ));
  localparam logic [DIV_W-1:0]  BPM_CAP   = DIV_W'(BPM_MAX);

  hr_state_t         state_r;
  hr_state_t         state_next_s;
  logic              peak_prev_r;
  logic              edge_s;
  logic [CNT_W-1:0]  interval_cnt_r;
  logic              cnt_ok_s;
  logic              cnt_max_s;
  logic [CNT_W-1:0]  hist_r [AVG_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic [SUM_W-1:0]  sum_r;
  logic [CNT_W-1:0]  oldest_s;
  logic [CNT_W-1:0]  avg_s;
  logic              full_s;
  logic              fill_last_s;
  logic              accept_s;
  logic              push_s;
  logic              flush_s;
  logic              timeout_s;
  logic              div_go_s;
  logic              done_write_s;
  logic              keep_s;
  logic              flush_req_s;
  logic              div_start_r;
  logic              div_start_s;
  logic              div_busy_s;
  logic              div_done_s;
  logic [DIV_W-1:0]  div_quo_s;
  logic [DIV_W-1:0]  divisor_s;
  logic [7:0]        rate_clamp_s;

  assign edge_s      = peak_in & ~peak_prev_r;
  assign cnt_ok_s    = (interval_cnt_r >= MIN_CNT);
  assign cnt_max_s   = (interval_cnt_r == MAX_CNT);
  assign full_s      = (fill_r == FILL_FULL);
  assign fill_last_s = (fill_r >= FILL_LAST);
  // Until the ring is full the slot being overwritten holds no interval.
  assign oldest_s    = full_s ? hist_r[wr_ptr_r] : '0;
  assign avg_s       = sum_r[SUM_W-1:AVG_L];
  assign divisor_s   = DIV_W'(avg_s);
  assign rate_clamp_s = (div_quo_s > BPM_CAP) ? 8'(BPM_MAX) : div_quo_s[7:0];
  assign div_start_s = div_start_r & ~div_busy_s;

`ifdef OUTLIER_REJECT_EN
  logic [CNT_W-1:0] quarter_s;
  logic [CNT_W-1:0] lo_s;
  logic [CNT_W:0]   hi_s;
  logic             outlier_s;
  logic             outlier_seen_r;

  assign quarter_s = avg_s >> 2;
  assign lo_s      = avg_s - quarter_s;
  assign hi_s      = {1'b0, avg_s} + {1'b0, quarter_s};
  assign outlier_s = full_s && ((interval_cnt_r < lo_s) || ({1'b0, interval_cnt_r} > hi_s));

  // Outliers are dropped; the second one in a row restarts the history.
  always_comb begin
    keep_s      = 1'b1;
    flush_req_s = 1'b0;
    if (outlier_s) begin
      keep_s      = 1'b0;
      flush_req_s = outlier_seen_r;
    end else begin
      keep_s      = 1'b1;
      flush_req_s = 1'b0;
    end
  end

  // Remembers whether the previous measured interval was an outlier.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outlier_seen_r <= 1'b0;
    end else if (timeout_s) begin
      outlier_seen_r <= 1'b0;
    end else if (accept_s && (state_r != S_WAIT_FIRST)) begin
      outlier_seen_r <= outlier_s & ~outlier_seen_r;
    end
  end
`else
  assign keep_s      = 1'b1;
  assign flush_req_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= S_WAIT_FIRST;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state and per-cycle control strobes.
  always_comb begin
    state_next_s = state_r;
    accept_s     = 1'b0;
    push_s       = 1'b0;
    flush_s      = 1'b0;
    timeout_s    = 1'b0;
    div_go_s     = 1'b0;
    done_write_s = 1'b0;
    case (state_r)
      S_WAIT_FIRST: begin
        if (edge_s) begin
          accept_s     = 1'b1;
          state_next_s = S_TRACK;
        end else begin
          state_next_s = S_WAIT_FIRST;
        end
      end
      S_TRACK: begin
        // An accepted edge takes priority over a coincident timeout.
        if (edge_s && cnt_ok_s) begin
          accept_s = 1'b1;
          push_s   = keep_s;
          flush_s  = flush_req_s;
          if (keep_s && fill_last_s) begin
            div_go_s     = 1'b1;
            state_next_s = S_DIV;
          end else begin
            state_next_s = S_TRACK;
          end
        end else if (cnt_max_s) begin
          timeout_s    = 1'b1;
          state_next_s = S_WAIT_FIRST;
        end else begin
          state_next_s = S_TRACK;
        end
      end
      S_DIV: begin
        if (edge_s && cnt_ok_s) begin
          accept_s = 1'b1;
          push_s   = keep_s;
          flush_s  = flush_req_s;
        end else begin
          accept_s = 1'b0;
        end
        if (!accept_s && cnt_max_s) begin
          timeout_s    = 1'b1;
          state_next_s = S_WAIT_FIRST;
        end else if (div_done_s) begin
          done_write_s = 1'b1;
          state_next_s = S_TRACK;
        end else begin
          state_next_s = S_DIV;
        end
      end
      default: begin
        state_next_s = S_WAIT_FIRST;
      end
    endcase
  end

  // Edge-detect history and saturating interval counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_prev_r    <= 1'b0;
      interval_cnt_r <= '0;
    end else begin
      peak_prev_r <= peak_in;
      if (accept_s) begin
        interval_cnt_r <= '0;
      end else if (!cnt_max_s) begin
        interval_cnt_r <= interval_cnt_r + CNT_W'(1);
      end
    end
  end

  // Ring buffer of intervals with running sum and fill level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      fill_r   <= '0;
      sum_r    <= '0;
    end else if (timeout_s) begin
      for (int i = 0; i < AVG_DEPTH; i++) begin
        hist_r[i] <= '0;
      end
      wr_ptr_r <= '0;
      fill_r   <= '0;
      sum_r    <= '0;
    end else if (flush_s) begin
      hist_r[0] <= interval_cnt_r;
      wr_ptr_r  <= PTR_W'(1);
      fill_r    <= FILL_W'(1);
      sum_r     <= SUM_W'(interval_cnt_r);
    end else if (push_s) begin
      hist_r[wr_ptr_r] <= interval_cnt_r;
      wr_ptr_r         <= wr_ptr_r + PTR_W'(1);
      sum_r            <= sum_r + SUM_W'(interval_cnt_r) - SUM_W'(oldest_s);
      fill_r           <= full_s ? fill_r : (fill_r + FILL_W'(1));
    end
  end

  // Divider start is issued the cycle after the push so it sees the new sum.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_start_r <= 1'b0;
    end else begin
      div_start_r <= div_go_s;
    end
  end

  seq_divider u_div (
    .clk      (clk),
    .reset    (reset),
    .clear    (timeout_s),
    .start    (div_start_s),
    .dividend (DIVIDEND),
    .divisor  (divisor_s),
    .busy     (div_busy_s),
    .done     (div_done_s),
    .quotient (div_quo_s)
  );

  // Registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      heart_rate  <= 8'd0;
      rate_valid  <= 1'b0;
      rate_update <= 1'b0;
      beat_pulse  <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      beat_pulse  <= accept_s;
      timeout     <= timeout_s;
      rate_update <= done_write_s;
      if (timeout_s) begin
        heart_rate <= 8'd0;
        rate_valid <= 1'b0;
      end else if (done_write_s) begin
        heart_rate <= rate_clamp_s;
        rate_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_beat_rate_meter.sv
`timescale 1ns/1ps
module tb_beat_rate_meter;

  localparam int CLK_HZ = 1000;
  localparam int MAX_I  = 2000;
  localparam int DEPTH  = 4;
  localparam int MIN_A  = 250;
  localparam int MIN_B  = 100;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [1:0]      peak = 2'b00;
  logic [1:0][7:0] hr;
  logic [1:0]      rv, ru, bp, to;

  beat_rate_meter #(.CLK_HZ(CLK_HZ), .MIN_INTERVAL(MIN_A), .MAX_INTERVAL(MAX_I), .AVG_DEPTH(DEPTH)) u_a (
    .clk(clk), .reset(reset), .peak_in(peak[0]), .heart_rate(hr[0]),
    .rate_valid(rv[0]), .rate_update(ru[0]), .beat_pulse(bp[0]), .timeout(to[0]));

  beat_rate_meter #(.CLK_HZ(CLK_HZ), .MIN_INTERVAL(MIN_B), .MAX_INTERVAL(MAX_I), .AVG_DEPTH(DEPTH)) u_b (
    .clk(clk), .reset(reset), .peak_in(peak[1]), .heart_rate(hr[1]),
    .rate_valid(rv[1]), .rate_update(ru[1]), .beat_pulse(bp[1]), .timeout(to[1]));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  // Interval measured at an edge = cycles since the previous accepted edge
  // minus one, capped at MAX_I. Result appears 35 cycles after the edge.
  int     min_of [2] = '{MIN_A, MIN_B};
  bit     m_track [2];
  bit     m_prev [2];
  longint m_tlast [2];
  int     m_iv [2][DEPTH];
  int     m_n [2];
  int     m_hr [2];
  int     m_valid [2];
  longint m_due [2];
  int     m_dval [2];
  bit     e_beat [2];
  bit     e_to [2];
  bit     e_upd [2];

  task automatic model_reset(input int i);
    m_track[i] = 1'b0; m_prev[i] = 1'b0; m_n[i] = 0;
    m_hr[i] = 0; m_valid[i] = 0; m_due[i] = -1;
    e_beat[i] = 1'b0; e_to[i] = 1'b0; e_upd[i] = 1'b0;
  endtask

  task automatic model_step(input int i, input bit smp, input longint v);
    longint c;
    longint el;
    int     iv;
    int     sum;
    int     q;
    bit     edg;
    c = v - 1;
    e_beat[i] = 1'b0; e_to[i] = 1'b0; e_upd[i] = 1'b0;
    if (m_due[i] == v) begin
      m_hr[i] = m_dval[i]; m_valid[i] = 1; e_upd[i] = 1'b1; m_due[i] = -1;
    end
    edg = smp && !m_prev[i];
    m_prev[i] = smp;
    if (!m_track[i]) begin
      if (edg) begin
        m_track[i] = 1'b1; m_tlast[i] = c; e_beat[i] = 1'b1;
      end
    end else begin
      el = c - m_tlast[i] - 1;
      iv = (el > MAX_I) ? MAX_I : int'(el);
      if (edg && iv >= min_of[i]) begin
        e_beat[i] = 1'b1;
        m_tlast[i] = c;
        if (m_n[i] < DEPTH) begin
          m_iv[i][m_n[i]] = iv; m_n[i]++;
        end else begin
          for (int k = 0; k < DEPTH - 1; k++) m_iv[i][k] = m_iv[i][k+1];
          m_iv[i][DEPTH-1] = iv;
        end
        if (m_n[i] == DEPTH) begin
          sum = 0;
          for (int k = 0; k < DEPTH; k++) sum += m_iv[i][k];
          q = (60 * CLK_HZ) / (sum / DEPTH);
          m_dval[i] = (q > 255) ? 255 : q;
          m_due[i] = c + 35;
        end
      end else if (el == MAX_I) begin
        e_to[i] = 1'b1; m_track[i] = 1'b0; m_hr[i] = 0; m_valid[i] = 0;
        m_n[i] = 0; m_due[i] = -1;
      end
    end
  endtask

  // ---------------- per-cycle compare ----------------
  longint     cyc = 0;
  logic [1:0] smp;
  logic       rs;
  int         cnt_beat [2] = '{0, 0};
  int         cnt_upd [2] = '{0, 0};
  int         cnt_to [2] = '{0, 0};
  longint     last_beat [2] = '{0, 0};
  int         upd_delta [2] = '{0, 0};
  string      pfx [2] = '{"a", "b"};

  always begin
    @(posedge clk);
    cyc++;
    smp = peak;
    rs  = reset;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rs || reset) model_reset(i);
      else model_step(i, smp[i], cyc);
      chk({pfx[i], ".heart_rate"}, int'(hr[i]), m_hr[i]);
      chk({pfx[i], ".rate_valid"}, int'(rv[i]), m_valid[i]);
      chk({pfx[i], ".rate_update"}, int'(ru[i]), int'(e_upd[i]));
      chk({pfx[i], ".beat_pulse"}, int'(bp[i]), int'(e_beat[i]));
      chk({pfx[i], ".timeout"}, int'(to[i]), int'(e_to[i]));
      if (bp[i]) begin cnt_beat[i]++; last_beat[i] = cyc; end
      if (ru[i]) begin cnt_upd[i]++; upd_delta[i] = int'(cyc - last_beat[i]); end
      if (to[i]) cnt_to[i]++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // n edges spaced gap cycles; peak held hold cycles; optional second
  // 1-cycle pulse at offset glitch (0 = none).
  task automatic train(input int i, input int gap, input int hold, input int glitch, input int n);
    repeat (n) begin
      for (int k = 0; k < gap; k++) begin
        peak[i] = ((k < hold) || (glitch != 0 && k == glitch)) ? 1'b1 : 1'b0;
        tick();
      end
    end
    peak[i] = 1'b0;
  endtask

  task automatic idle(input int n);
    peak = 2'b00;
    repeat (n) tick();
  endtask

  int gap, hold, glitch, beats_before;

  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk("reset.heart_rate", int'(hr[0]), 0);
    chk("reset.rate_valid", int'(rv[0]), 0);
    reset = 1'b0;
    tick();

    // steady 800-cycle beats
    train(0, 800, 1, 0, 6);
    chk("steady.beats", cnt_beat[0], 6);
    chk("steady.updates", cnt_upd[0], 2);
    chk("steady.heart_rate", int'(hr[0]), 75);
    chk("steady.rate_valid", int'(rv[0]), 1);
    chk("steady.latency", upd_delta[0], 34);

    // extra edge 100 cycles after each beat is refractory
    train(0, 800, 1, 100, 3);
    chk("refractory.beats", cnt_beat[0], 9);
    chk("refractory.heart_rate", int'(hr[0]), 75);

    // long-held level counts once
    train(0, 800, 300, 0, 3);
    chk("held.beats", cnt_beat[0], 12);
    chk("held.heart_rate", int'(hr[0]), 75);

    // timeout and recovery
    idle(2100);
    chk("timeout.count", cnt_to[0], 1);
    chk("timeout.heart_rate", int'(hr[0]), 0);
    chk("timeout.rate_valid", int'(rv[0]), 0);
    train(0, 800, 1, 0, 4);
    chk("recover4.rate_valid", int'(rv[0]), 0);
    train(0, 800, 1, 0, 1);
    chk("recover5.rate_valid", int'(rv[0]), 1);
    chk("recover5.heart_rate", int'(hr[0]), 75);

    // reset while dividing
    peak[0] = 1'b1; tick(); peak[0] = 1'b0;
    repeat (10) tick();
    reset = 1'b1; #1;
    chk("rst_div.heart_rate", int'(hr[0]), 0);
    chk("rst_div.rate_valid", int'(rv[0]), 0);
    chk("rst_div.beat_pulse", int'(bp[0]), 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    train(0, 800, 1, 0, 4);
    chk("after_rst4.rate_valid", int'(rv[0]), 0);
    train(0, 800, 1, 0, 1);
    chk("after_rst5.rate_valid", int'(rv[0]), 1);

    // acceptance / timeout boundaries: 2001 (edge meets MAX), 251, 250
    beats_before = cnt_beat[0];
    train(0, 800, 1, 0, 1);
    train(0, 2001, 1, 0, 1);
    train(0, 251, 1, 0, 1);
    train(0, 250, 1, 0, 1);
    train(0, 800, 1, 0, 1);
    train(0, 800, 1, 0, 1);
    chk("boundary.beats", cnt_beat[0] - beats_before, 5);
    chk("boundary.timeouts", cnt_to[0], 1);

    // fast beats clamp at 255
    train(1, 200, 1, 0, 6);
    chk("clamp.heart_rate", int'(hr[1]), 255);
    chk("clamp.rate_valid", int'(rv[1]), 1);

    // randomized beats, glitches and long gaps
    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 9) == 0) gap = $urandom_range(1950, 2100);
      else gap = $urandom_range(240, 1100);
      hold = $urandom_range(1, 200);
      if (hold >= gap - 4) hold = 1;
      glitch = 0;
      if ($urandom_range(0, 2) == 0 && gap > hold + 6) glitch = $urandom_range(hold + 2, gap - 2);
      train(0, gap, hold, glitch, 1);
    end
    idle(2100);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
